audio_mixer_n_ch: RTL and testbench

//  Parametrised N-channel PCM mixer: for each output sample it fetches one sample per active channel from

---
 rtl/audio_mix_pkg.sv | 37 +++
 rtl/audio_mix_mac.sv | 53 +++++
 rtl/audio_mixer_n_ch.sv | 218 +++++++++++++++++++++
 tb/tb_audio_mixer_n_ch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
// rtl/audio_mix_pkg.sv - shared types, register map and sizing helpers for the N-channel audio mixer
package audio_mix_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_RD_REQ,
    S_MAC,
    S_WR_REQ,
    S_DONE
  } state_t;

  // Fields are sized for the widest supported configuration (32-bit addresses, 16-bit volume).
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] start_addr;
    logic [31:0] start_len;
    logic [15:0] vol;
    logic        en;
    logic        loop;
  } chan_cfg_t;

  localparam logic [7:0] REG_MADDR   = 8'h00;
  localparam logic [7:0] REG_MLEN    = 8'h01;
  localparam logic [7:0] REG_CTRL    = 8'h02;
  localparam logic [7:0] REG_STATUS  = 8'h03;
  localparam logic [1:0] CH_ADDR     = 2'd0;
  localparam logic [1:0] CH_LEN      = 2'd1;
  localparam logic [1:0] CH_VOL      = 2'd2;
  localparam logic [1:0] CH_CTRL     = 2'd3;

  function automatic int acc_w(input int sample_w, input int vol_w, input int n_chan);
    return sample_w + vol_w + $clog2(n_chan) + 1;
  endfunction

endpackage

// File: rtl/audio_mix_mac.sv
// rtl/audio_mix_mac.sv - signed x unsigned multiply-accumulate with floor shift and output saturation
module audio_mix_mac
  import audio_mix_pkg::*;
#(
  parameter int N_CHAN   = 8,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic        [VOL_W-1:0]    vol_i,
  output logic        [SAMPLE_W-1:0] sat_o
);

  localparam int ACC_W = acc_w(SAMPLE_W, VOL_W, N_CHAN);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_x;
  logic signed [ACC_W-1:0] vol_x;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] shifted;

  // Widening both operands to the accumulator width keeps the product exact.
  assign sample_x = {{(ACC_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};
  assign vol_x    = {{(ACC_W-VOL_W){1'b0}}, vol_i};
  assign prod     = sample_x * vol_x;
  assign shifted  = acc >>> (VOL_W - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc <= '0;
    end else if (clr_i) begin
      acc <= '0;
    end else if (en_i) begin
      acc <= acc + prod;
    end
  end

  always_comb begin
    sat_o = shifted[SAMPLE_W-1:0];
    if (shifted > MAX_V) begin
      sat_o = MAX_V[SAMPLE_W-1:0];
    end else if (shifted < MIN_V) begin
      sat_o = MIN_V[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/audio_mixer_n_ch.sv
// rtl/audio_mixer_n_ch.sv - N-channel PCM mixer: register bank, fetch/scale/sum engine and master buffer writer
module audio_mixer_n_ch
  import audio_mix_pkg::*;
#(
  parameter int N_CHAN   = 8,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 8,
  parameter int MADDR_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [7:0]          addr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  output logic                ack_o,
  output logic                irq_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [MADDR_W-1:0]  mem_addr_o,
  output logic [SAMPLE_W-1:0] mem_wdat_o,
  input  logic [SAMPLE_W-1:0] mem_rdat_i,
  input  logic                mem_ack_i
);

  localparam logic [31:0] STEP = 32'(SAMPLE_W / 8);
  localparam int IDX_W = $clog2(N_CHAN + 1);
  localparam int SEL_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_CHAN);

  state_t                      state;
  chan_cfg_t                   ch [N_CHAN];
  logic [31:0]                 m_addr;
  logic [31:0]                 m_len;
  logic                        done;
  logic                        aborted;
  logic                        abort_pend;
  logic                        fetched;
  logic [IDX_W-1:0]            idx;
  logic [SEL_W-1:0]            sel;
  logic signed [SAMPLE_W-1:0]  sample_q;
  logic [SAMPLE_W-1:0]         sat;
  logic [31:0]                 rdata;
  logic                        busy;
  logic                        wr;
  logic                        start_cmd;
  logic                        abort_cmd;
  logic                        mac_clr;
  logic                        mac_en;

  assign sel       = idx[SEL_W-1:0];
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign wr        = stb_i && we_i;
  assign abort_cmd = wr && (addr_i == REG_CTRL) && dat_i[1];
  assign start_cmd = wr && (addr_i == REG_CTRL) && dat_i[0] && !dat_i[1];
  assign irq_o     = done;
  assign mac_en    = (state == S_MAC);
  assign mac_clr   = (state == S_IDLE) || (state == S_DONE) || ((state == S_WR_REQ) && mem_ack_i);

  function automatic logic [31:0] dec(input logic [31:0] v);
    return (v < STEP) ? 32'd0 : v - STEP;
  endfunction

  audio_mix_mac #(
    .N_CHAN   (N_CHAN),
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .sample_i (sample_q),
    .vol_i    (ch[sel].vol[VOL_W-1:0]),
    .sat_o    (sat)
  );

  always_comb begin
    rdata = '0;
    case (addr_i)
      REG_MADDR:  rdata = m_addr;
      REG_MLEN:   rdata = m_len;
      REG_STATUS: rdata = {29'd0, aborted, done, busy};
      default:    rdata = '0;
    endcase
    for (int k = 0; k < N_CHAN; k++) begin
      if (addr_i[7] && (addr_i[6:2] == 5'(k))) begin
        case (addr_i[1:0])
          CH_ADDR: rdata = ch[k].addr;
          CH_LEN:  rdata = ch[k].len;
          CH_VOL:  rdata = 32'(ch[k].vol);
          default: rdata = {30'd0, ch[k].loop, ch[k].en};
        endcase
      end
    end
  end

  // Register writes come first so that any engine update later in this block wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      m_addr     <= '0;
      m_len      <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      fetched    <= 1'b0;
      idx        <= '0;
      sample_q   <= '0;
      dat_o      <= '0;
      ack_o      <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_wdat_o <= '0;
      for (int k = 0; k < N_CHAN; k++) ch[k] <= '0;
    end else begin
      ack_o <= stb_i;
      dat_o <= (stb_i && !we_i) ? rdata : 32'd0;

      if (wr && !busy) begin
        if (addr_i == REG_MADDR) m_addr <= dat_i;
        if (addr_i == REG_MLEN)  m_len  <= dat_i;
      end
      for (int k = 0; k < N_CHAN; k++) begin
        if (wr && addr_i[7] && (addr_i[6:2] == 5'(k))) begin
          if (addr_i[1:0] == CH_VOL) ch[k].vol <= 16'(dat_i[VOL_W-1:0]);
          if (!busy) begin
            case (addr_i[1:0])
              CH_ADDR: begin ch[k].addr <= dat_i; ch[k].start_addr <= dat_i; end
              CH_LEN:  begin ch[k].len  <= dat_i; ch[k].start_len  <= dat_i; end
              CH_CTRL: begin ch[k].en   <= dat_i[0]; ch[k].loop <= dat_i[1]; end
              default: ;
            endcase
          end
        end
      end
      if (wr && (addr_i == REG_STATUS)) begin
        if (dat_i[1]) done    <= 1'b0;
        if (dat_i[2]) aborted <= 1'b0;
      end
      if (abort_cmd && busy) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_cmd) begin
            state   <= S_SCAN;
            idx     <= '0;
            fetched <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
          end
        end
        S_SCAN: begin
          if (abort_pend || (m_len == 32'd0)) begin
            state <= S_DONE;
          end else if (idx == IDX_END) begin
            if (fetched) begin
              state      <= S_WR_REQ;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b1;
              mem_addr_o <= m_addr[MADDR_W-1:0];
              mem_wdat_o <= sat;
            end else begin
              state <= S_DONE;
            end
          end else if (ch[sel].en && (ch[sel].len != 32'd0)) begin
            state      <= S_RD_REQ;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= ch[sel].addr[MADDR_W-1:0];
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_RD_REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            sample_q  <= mem_rdat_i;
            state     <= abort_pend ? S_DONE : S_MAC;
          end
        end
        S_MAC: begin
          ch[sel].addr <= ch[sel].addr + STEP;
          ch[sel].len  <= dec(ch[sel].len);
          if ((dec(ch[sel].len) == 32'd0) && ch[sel].loop) begin
            ch[sel].addr <= ch[sel].start_addr;
            ch[sel].len  <= ch[sel].start_len;
          end
          fetched <= 1'b1;
          idx     <= idx + IDX_W'(1);
          state   <= S_SCAN;
        end
        S_WR_REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            m_addr    <= m_addr + STEP;
            m_len     <= dec(m_len);
            idx       <= '0;
            fetched   <= 1'b0;
            state     <= S_SCAN;
          end
        end
        S_DONE: begin
          if (abort_pend) aborted <= 1'b1;
          else            done    <= 1'b1;
          abort_pend <= 1'b0;
          idx        <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer_n_ch.sv
// tb/tb_audio_mixer_n_ch.sv - scoreboard bench for audio_mixer_n_ch with a behavioural mixing model
module tb_audio_mixer_n_ch;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] dat = 32'd0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq_o;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdat;
  logic [15:0] mem_rdat;
  logic        mem_ack;

  always #5 clk = ~clk;

  audio_mixer_n_ch #(.N_CHAN(N), .SAMPLE_W(16), .VOL_W(8), .MADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .we_i(we), .addr_i(addr), .dat_i(dat),
    .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdat_o(mem_wdat), .mem_rdat_i(mem_rdat), .mem_ack_i(mem_ack)
  );

  typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [7:0] addr; logic [31:0] exp; } rd_t;

  wr_t  wr_q[$];
  rd_t  rd_q[$];
  bit   acc_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   hold_delay = -1;
  int   req_cnt = 0;
  int   run_len = 0;
  int   last_hold = 0;
  logic [15:0] mem [0:4095];

  int c_addr[N], c_len[N], c_vol[N];
  bit c_en[N], c_loop[N];
  int m_addr_c, m_len_c;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory slave: random (or forced) ack latency per request.
  initial begin
    bit in_req;
    int wait_cnt;
    in_req = 0;
    wait_cnt = 0;
    mem_ack = 1'b0;
    mem_rdat = 16'd0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!in_req) begin
          in_req = 1;
          wait_cnt = (hold_delay >= 0) ? hold_delay : int'($urandom_range(0, 3));
        end
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          in_req = 0;
          if (!mem_we) mem_rdat = mem[mem_addr[12:1]];
        end else begin
          wait_cnt--;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  // Monitor: compares master writes and register reads against queued expectations.
  initial begin
    bit   prev_req;
    bit   is_rd;
    wr_t  e;
    rd_t  r;
    prev_req = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req && !prev_req) req_cnt++;
      prev_req = mem_req;
      if (mem_req) run_len++;
      else if (run_len != 0) begin last_hold = run_len; run_len = 0; end
      if (mem_req && mem_ack && mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdat, e.data);
        end
      end
      if (ack_o) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          is_rd = acc_q.pop_front();
          if (is_rd) begin
            r = rd_q.pop_front();
            chk($sformatf("reg_rd_%02h", r.addr), dat_o, r.exp);
          end
        end
      end
    end
  end

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    acc_q.push_back(1'b0);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = a; dat = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [31:0] e);
    rd_t r;
    r.addr = a; r.exp = e;
    rd_q.push_back(r);
    acc_q.push_back(1'b1);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic program_ch(input int k, input int a, input int l, input int v, input bit en, input bit lp);
    c_addr[k] = a; c_len[k] = l; c_vol[k] = v; c_en[k] = en; c_loop[k] = lp;
    reg_wr(8'(8'h80 + 4 * k),     32'(a));
    reg_wr(8'(8'h80 + 4 * k + 1), 32'(l));
    reg_wr(8'(8'h80 + 4 * k + 2), 32'(v));
    reg_wr(8'(8'h80 + 4 * k + 3), {30'd0, lp, en});
  endtask

  task automatic set_master(input int a, input int l);
    m_addr_c = a; m_len_c = l;
    reg_wr(8'h00, 32'(a));
    reg_wr(8'h01, 32'(l));
  endtask

  task automatic disable_all();
    for (int k = 0; k < N; k++) begin
      c_en[k] = 0;
      reg_wr(8'(8'h80 + 4 * k + 3), 32'd0);
    end
  endtask

  function automatic logic [15:0] sat_floor(input longint acc);
    longint q;
    logic [63:0] qv;
    q = acc / 128;
    if (acc < 0 && q * 128 != acc) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    qv = q;
    return qv[15:0];
  endfunction

  // Mixing reference: one frame per output sample, channels visited in order.
  task automatic model_run();
    longint a[N], l[N];
    longint acc, maddr, mlen;
    bit any;
    wr_t w;
    for (int k = 0; k < N; k++) begin a[k] = c_addr[k]; l[k] = c_len[k]; end
    maddr = m_addr_c; mlen = m_len_c;
    while (mlen != 0) begin
      acc = 0; any = 0;
      for (int k = 0; k < N; k++) begin
        if (c_en[k] && l[k] != 0) begin
          any = 1;
          acc += longint'($signed(mem[a[k] / 2])) * c_vol[k];
          a[k] += 2;
          l[k] = (l[k] < 2) ? 0 : l[k] - 2;
          if (l[k] == 0 && c_loop[k]) begin a[k] = c_addr[k]; l[k] = c_len[k]; end
        end
      end
      if (!any) break;
      w.addr = 32'(maddr); w.data = sat_floor(acc);
      wr_q.push_back(w);
      maddr += 2;
      mlen = (mlen < 2) ? 0 : mlen - 2;
    end
  endtask

  task automatic go_and_wait(input string name);
    int cnt;
    reg_wr(8'h02, 32'd1);
    cnt = 0;
    while (!irq_o && cnt < 5000) begin @(negedge clk); cnt++; end
    chk({name, "_irq"}, irq_o, 1);
    chk({name, "_pending_writes"}, wr_q.size(), 0);
    reg_rd(8'h03, 32'h2);
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.addr = 32'(a); w.data = 16'(d);
    wr_q.push_back(w);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, reqs;
    for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_ack", ack_o, 0);
    rst_n = 1'b1;
    reg_rd(8'h03, 32'd0);
    reg_rd(8'h00, 32'd0);
    reg_rd(8'h01, 32'd0);
    reg_rd(8'h82, 32'd0);
    reg_rd(8'h8F, 32'd0);
    reg_wr(8'h40, 32'hFFFF_FFFF);
    reg_rd(8'h40, 32'd0);

    // Unity gain, single channel.
    for (int i = 0; i < 4; i++) mem[12'h080 + i] = 16'h1000;
    program_ch(0, 'h100, 8, 'h80, 1, 0);
    set_master('h1000, 8);
    for (int i = 0; i < 4; i++) push_wr('h1000 + 2 * i, 'h1000);
    go_and_wait("unity");
    reg_rd(8'h00, 32'h1008);
    reg_rd(8'h01, 32'd0);
    reg_wr(8'h03, 32'h6);
    reg_rd(8'h03, 32'd0);
    chk("irq_cleared", irq_o, 0);

    // Positive and negative saturation.
    mem[12'h080] = 16'h7000; mem[12'h100] = 16'h7000;
    program_ch(0, 'h100, 2, 'hFF, 1, 0);
    program_ch(1, 'h200, 2, 'hFF, 1, 0);
    set_master('h1000, 2);
    push_wr('h1000, 'h7FFF);
    go_and_wait("sat_pos");
    mem[12'h080] = 16'h9000; mem[12'h100] = 16'h9000;
    program_ch(0, 'h100, 2, 'hFF, 1, 0);
    program_ch(1, 'h200, 2, 'hFF, 1, 0);
    set_master('h1000, 2);
    push_wr('h1000, 'h8000);
    go_and_wait("sat_neg");

    // Looping channel wraps back to its start address.
    disable_all();
    mem[12'h080] = 16'd1; mem[12'h081] = 16'd2;
    program_ch(0, 'h100, 4, 'h80, 1, 1);
    set_master('h1000, 12);
    for (int i = 0; i < 6; i++) push_wr('h1000 + 2 * i, (i % 2) + 1);
    go_and_wait("loop");
    reg_rd(8'h80, 32'h100);
    reg_rd(8'h81, 32'd4);

    // Randomised mixes against the reference model.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < 8; i++) mem[12'h080 + 12'h080 * k + i] = 16'($urandom);
        program_ch(k, 'h100 + 'h100 * k, 2 * int'($urandom_range(1, 4)), int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      set_master('h1000, int'($urandom_range(1, 12)));
      model_run();
      go_and_wait("random");
    end

    // All channels disabled: no memory traffic and a prompt done.
    disable_all();
    set_master('h1000, 8);
    reqs = req_cnt;
    reg_wr(8'h02, 32'd1);
    cnt = 0;
    while (!irq_o && cnt < 100) begin @(negedge clk); cnt++; end
    chk("idle_irq", irq_o, 1);
    chk("idle_done_in_time", (cnt <= N + 2), 1);
    chk("idle_no_requests", req_cnt - reqs, 0);

    // Abort while a read is held off: request completes, no write, aborted only.
    mem[12'h080] = 16'h1234;
    program_ch(0, 'h100, 8, 'h80, 1, 0);
    set_master('h1000, 8);
    hold_delay = 10;
    reg_wr(8'h02, 32'd1);
    cnt = 0;
    while (!mem_req && cnt < 100) begin @(negedge clk); cnt++; end
    chk("abort_req_seen", mem_req, 1);
    reg_wr(8'h02, 32'd2);
    cnt = 0;
    while (mem_req && cnt < 100) begin @(negedge clk); cnt++; end
    repeat (6) @(negedge clk);
    chk("abort_req_held", (last_hold >= 10), 1);
    reg_rd(8'h03, 32'h4);
    chk("abort_irq", irq_o, 0);
    hold_delay = -1;

    // Reset with a request outstanding.
    hold_delay = 10;
    reg_wr(8'h02, 32'd1);
    cnt = 0;
    while (!mem_req && cnt < 100) begin @(negedge clk); cnt++; end
    chk("rst_req_seen", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_req", mem_req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_delay = -1;
    reg_rd(8'h03, 32'd0);
    reg_rd(8'h00, 32'd0);
    reg_rd(8'h01, 32'd0);
    reg_rd(8'h80, 32'd0);
    reg_rd(8'h82, 32'd0);
    reg_rd(8'h83, 32'd0);

    repeat (5) @(negedge clk);
    chk("acc_queue_drained", acc_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
